// File: rtl/pcie_datalink_pkg.sv
// Shared types and helpers for the DLL transmit-path replay buffer.
//   replay_desc_t : per-frame descriptor {start_ptr, end_ptr, seq}. Fields are
//                   sized for the largest supported configuration; users cast
//                   them down to their own pointer and sequence widths.
//   seq_diff      : modulo subtraction (a - b) mod 2^width.
//   REPLAY_NUM_W  : width of the REPLAY_NUM counter (wraps after 4 replays).
package pcie_datalink_pkg;

    localparam int REPLAY_NUM_W = 2;
    localparam int PTR_MAX_W    = 16;
    localparam int SEQ_MAX_W    = 16;

    typedef struct packed {
        logic [PTR_MAX_W-1:0] start_ptr;
        logic [PTR_MAX_W-1:0] end_ptr;
        logic [SEQ_MAX_W-1:0] seq;
    } replay_desc_t;

    function automatic logic [SEQ_MAX_W-1:0] seq_diff(
        input logic [SEQ_MAX_W-1:0] a,
        input logic [SEQ_MAX_W-1:0] b,
        input int unsigned          width
    );
        logic [SEQ_MAX_W-1:0] mask;
        mask = {SEQ_MAX_W{1'b1}} >> (SEQ_MAX_W - width);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/replay_buffer_ram.sv
// Simple dual-port beat store for the replay buffer.
//   clk     : write clock
//   wr_en   : write strobe, wr_addr/wr_data captured on the rising edge
//   rd_addr : asynchronous read address, rd_data follows combinationally
// Holds only data, so it carries no reset.
module replay_buffer_ram #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_replay_buffer.sv
// Multi-frame TLP replay buffer for the DLL transmit path.
// Stores whole AXIS frames, tags each with a sequence number, transmits each
// once in order and keeps it until an ACK/NAK purges it. NAK or replay timer
// retransmits every sent-but-unacked frame, oldest first.
//   s_axis_*        : TLP input (store-and-forward)
//   m_axis_*        : TLP output to the framer, m_axis_seq_o tags the frame
//   ack_*_i         : received ACK/NAK DLLP, replay_req_i : replay timer
//   next_seq_o, frames_pending_o, free_words_o : status
//   replay_active_o, replay_rollover_o, ack_err_o : replay / error indication
module axis_replay_buffer
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH_WORDS = 512,
    parameter int MAX_FRAMES  = 16,
    parameter int SEQ_WIDTH   = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [SEQ_WIDTH-1:0]          m_axis_seq_o,
    input  logic                          ack_valid_i,
    input  logic                          ack_nak_i,
    input  logic [SEQ_WIDTH-1:0]          ack_seq_i,
    input  logic                          replay_req_i,
    output logic [SEQ_WIDTH-1:0]          next_seq_o,
    output logic [$clog2(MAX_FRAMES):0]   frames_pending_o,
    output logic [$clog2(DEPTH_WORDS):0]  free_words_o,
    output logic                          replay_active_o,
    output logic                          replay_rollover_o,
    output logic                          ack_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(MAX_FRAMES);
    localparam int IW = FW + 1;   // frame indices carry a wrap bit so full != empty
    localparam int BW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    typedef enum logic {ST_IDLE, ST_XMIT} state_t;

    state_t                  state, state_nx;
    logic [AW-1:0]           wr_ptr, rd_ptr, rd_ptr_nx, cur_start, start_sel, span;
    logic                    in_frame;
    logic [AW:0]             free_words, free_nx, freed;
    logic [IW-1:0]           commit_idx, oldest_idx, tx_idx, hwm_idx;
    logic [IW-1:0]           pending, sent_window, purge_cnt, oldest_nx;
    logic [IW-1:0]           tx_base, tx_nx, hwm_nx, hwm_ahead;
    logic [FW-1:0]           last_slot;
    logic [SEQ_WIDTH-1:0]    next_seq, oldest_seq, ack_n;
    logic [REPLAY_NUM_W-1:0] replay_num, replay_num_nx, num_base;
    logic                    replay_pending, pending_nx, replay_active, active_nx;
    logic                    rollover, rollover_nx, ack_err, ack_err_nx;
    logic                    wr_en, commit, purge, ack_dup, ack_in_win, replay_arm;
    logic                    xfer, frame_done, at_boundary, start_replay, tx_behind;
    logic [BW-1:0]           wr_beat, rd_beat;
    replay_desc_t            desc_mem [MAX_FRAMES];
    replay_desc_t            old_desc, last_desc;

    // Write side: a descriptor slot must be free before a new frame may start.
    assign pending       = commit_idx - oldest_idx;
    assign s_axis_tready = (free_words != '0) && !((pending == IW'(MAX_FRAMES)) && !in_frame);
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign commit        = wr_en && s_axis_tlast;
    assign start_sel     = in_frame ? cur_start : wr_ptr;
    assign wr_beat       = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

    replay_buffer_ram #(.WIDTH(BW), .DEPTH(DEPTH_WORDS)) u_ram (
        .clk     (clk_i),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr),
        .rd_data (rd_beat)
    );

    always_ff @(posedge clk_i) begin
        if (commit) begin
            desc_mem[commit_idx[FW-1:0]] <= '{start_ptr: PTR_MAX_W'(start_sel),
                                             end_ptr:   PTR_MAX_W'(wr_ptr),
                                             seq:       SEQ_MAX_W'(next_seq)};
        end
    end

    // ACK/NAK decode. The oldest stored seq is implied by next_seq and the
    // number of committed frames, so it stays valid even with nothing stored.
    assign oldest_seq  = next_seq - SEQ_WIDTH'(pending);
    assign ack_n       = SEQ_WIDTH'(seq_diff(SEQ_MAX_W'(ack_seq_i), SEQ_MAX_W'(oldest_seq), SEQ_WIDTH)
                                     + SEQ_MAX_W'(1));
    assign sent_window = hwm_idx - oldest_idx;
    assign ack_dup     = (ack_n == '0);
    assign ack_in_win  = !ack_dup && (ack_n <= SEQ_WIDTH'(sent_window));
    assign purge       = ack_valid_i && ack_in_win;
    assign purge_cnt   = purge ? IW'(ack_n) : '0;
    assign oldest_nx   = oldest_idx + purge_cnt;
    assign last_slot   = FW'(oldest_nx - IW'(1));
    assign old_desc    = desc_mem[oldest_idx[FW-1:0]];
    assign last_desc   = desc_mem[last_slot];
    // Purged frames are contiguous in the RAM: free from the oldest start up to
    // the end of the last purged frame.
    assign span        = AW'(last_desc.end_ptr) - AW'(old_desc.start_ptr);
    assign freed       = purge ? ({1'b0, span} + (AW+1)'(1)) : '0;
    // Decided against the post-purge window so only surviving frames replay.
    assign replay_arm  = (replay_req_i || (ack_valid_i && ack_nak_i && (ack_in_win || ack_dup)))
                         && (hwm_idx != oldest_nx);

    // Transmit side
    assign xfer         = (state == ST_XMIT) && m_axis_tready;
    assign frame_done   = xfer && rd_beat[BW-1];
    assign at_boundary  = (state == ST_IDLE) || frame_done;
    assign tx_base      = frame_done ? tx_idx + IW'(1) : tx_idx;
    assign hwm_ahead    = tx_base - hwm_idx;
    assign start_replay = at_boundary && replay_pending;
    // tx may be left pointing at a frame that an ACK purged mid-transmission.
    assign tx_behind    = (commit_idx - tx_base) > (commit_idx - oldest_nx);

    always_comb begin
        state_nx      = state;
        tx_nx         = tx_idx;
        rd_ptr_nx     = rd_ptr;
        hwm_nx        = hwm_idx;
        active_nx     = replay_active;
        num_base      = purge ? '0 : replay_num;
        replay_num_nx = num_base;
        rollover_nx   = 1'b0;
        pending_nx    = replay_arm || (replay_pending && !start_replay);
        ack_err_nx    = ack_valid_i && !ack_in_win && !ack_dup;
        free_nx       = free_words - (AW+1)'(wr_en) + freed;

        if (frame_done && (hwm_ahead != '0) && (hwm_ahead <= IW'(MAX_FRAMES))) begin
            hwm_nx = tx_base;
        end
        if (at_boundary) begin
            tx_nx     = (start_replay || tx_behind) ? oldest_nx : tx_base;
            rd_ptr_nx = AW'(desc_mem[tx_nx[FW-1:0]].start_ptr);
            state_nx  = (tx_nx != commit_idx) ? ST_XMIT : ST_IDLE;
            if (start_replay) begin
                active_nx = 1'b1;
            end else if (tx_nx == hwm_nx) begin
                active_nx = 1'b0;
            end
        end else if (xfer) begin
            rd_ptr_nx = rd_ptr + AW'(1);
        end
        if (start_replay) begin
            replay_num_nx = num_base + REPLAY_NUM_W'(1);
            rollover_nx   = (num_base == '1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cur_start      <= '0;
            in_frame       <= 1'b0;
            free_words     <= (AW+1)'(DEPTH_WORDS);
            commit_idx     <= '0;
            oldest_idx     <= '0;
            tx_idx         <= '0;
            hwm_idx        <= '0;
            next_seq       <= '0;
            replay_num     <= '0;
            replay_pending <= 1'b0;
            replay_active  <= 1'b0;
            rollover       <= 1'b0;
            ack_err        <= 1'b0;
        end else begin
            state          <= state_nx;
            rd_ptr         <= rd_ptr_nx;
            free_words     <= free_nx;
            oldest_idx     <= oldest_nx;
            tx_idx         <= tx_nx;
            hwm_idx        <= hwm_nx;
            replay_num     <= replay_num_nx;
            replay_pending <= pending_nx;
            replay_active  <= active_nx;
            rollover       <= rollover_nx;
            ack_err        <= ack_err_nx;
            if (wr_en) begin
                wr_ptr    <= wr_ptr + AW'(1);
                in_frame  <= !s_axis_tlast;
                cur_start <= start_sel;
            end
            if (commit) begin
                commit_idx <= commit_idx + IW'(1);
                next_seq   <= next_seq + SEQ_WIDTH'(1);
            end
        end
    end

    assign m_axis_tvalid = (state == ST_XMIT);
    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = m_axis_tvalid ? rd_beat : '0;
    assign m_axis_seq_o  = m_axis_tvalid ? SEQ_WIDTH'(desc_mem[tx_idx[FW-1:0]].seq) : '0;

    assign next_seq_o        = next_seq;
    assign frames_pending_o  = pending;
    assign free_words_o      = free_words;
    assign replay_active_o   = replay_active;
    assign replay_rollover_o = rollover;
    assign ack_err_o         = ack_err;

endmodule

// File: tb/tb_axis_replay_buffer.sv
// Directed bench for axis_replay_buffer: stores frames, drains them, and
// exercises ACK/NAK purge, replays, REPLAY_NUM rollover, slot-full
// backpressure, sequence wrap and asynchronous reset.
module tb_axis_replay_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '1;
    logic [0:0]  s_axis_tuser = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic [0:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [11:0] m_axis_seq_o;
    logic        ack_valid = 1'b0;
    logic        ack_nak = 1'b0;
    logic [11:0] ack_seq = '0;
    logic        replay_req = 1'b0;
    logic [11:0] next_seq_o;
    logic [4:0]  frames_pending_o;
    logic [9:0]  free_words_o;
    logic        replay_active_o;
    logic        replay_rollover_o;
    logic        ack_err_o;

    always #5 clk = ~clk;

    axis_replay_buffer dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready),
        .m_axis_seq_o      (m_axis_seq_o),
        .ack_valid_i       (ack_valid),
        .ack_nak_i         (ack_nak),
        .ack_seq_i         (ack_seq),
        .replay_req_i      (replay_req),
        .next_seq_o        (next_seq_o),
        .frames_pending_o  (frames_pending_o),
        .free_words_o      (free_words_o),
        .replay_active_o   (replay_active_o),
        .replay_rollover_o (replay_rollover_o),
        .ack_err_o         (ack_err_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [11:0] seq;
        logic        act;
    } beat_t;

    beat_t q[$];
    int    roll_cnt = 0;
    int    err_cnt  = 0;
    int    errors   = 0;
    int    checks   = 0;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready)
            q.push_back('{data: m_axis_tdata, last: m_axis_tlast, seq: m_axis_seq_o, act: replay_active_o});
        if (replay_rollover_o) roll_cnt++;
        if (ack_err_o) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        q.delete();
        roll_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int k;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        k = 0;
        while (!s_axis_tready && k < 2000) begin
            tick(1);
            k++;
        end
        if (k >= 2000) chk("s_ready_timeout", 32'(k), 32'd0);
        tick(1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) send_beat(base + 32'(i), i == len - 1);
    endtask

    task automatic ack(input logic nak, input logic [11:0] s);
        ack_valid = 1'b1;
        ack_nak   = nak;
        ack_seq   = s;
        tick(1);
        ack_valid = 1'b0;
        ack_nak   = 1'b0;
    endtask

    task automatic replay();
        replay_req = 1'b1;
        tick(1);
        replay_req = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k;
        k = 0;
        while (q.size() < n && k < 500) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(q.size()), 32'(n));
    endtask

    initial begin
        int cnt;
        int guard;

        // 1: single frame, backpressure, ACK purge
        do_reset();
        chk("rst_next_seq", 32'(next_seq_o), 32'd0);
        chk("rst_free", 32'(free_words_o), 32'd512);
        chk("rst_pending", 32'(frames_pending_o), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd1);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_active", 32'(replay_active_o), 32'd0);
        m_axis_tready = 1'b0;
        send_frame(3, 32'hA0);
        tick(1);
        chk("t1_hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("t1_hold_data", m_axis_tdata, 32'hA0);
        chk("t1_free", 32'(free_words_o), 32'd509);
        chk("t1_pending", 32'(frames_pending_o), 32'd1);
        chk("t1_next_seq", 32'(next_seq_o), 32'd1);
        m_axis_tready = 1'b1;
        wait_beats("t1_beats", 3);
        chk("t1_d2", q[2].data, 32'hA2);
        chk("t1_last1", 32'(q[1].last), 32'd0);
        chk("t1_last2", 32'(q[2].last), 32'd1);
        chk("t1_seq", 32'(q[2].seq), 32'd0);
        tick(2);
        ack(1'b0, 12'd0);
        chk("t1_ack_free", 32'(free_words_o), 32'd512);
        chk("t1_ack_pending", 32'(frames_pending_o), 32'd0);

        // 2: NAK purges frame 0 and replays 1 and 2
        do_reset();
        send_frame(2, 32'hB0);
        send_frame(1, 32'hC0);
        send_frame(2, 32'hD0);
        wait_beats("t2_first", 5);
        tick(2);
        q.delete();
        ack(1'b1, 12'd0);
        chk("t2_pending", 32'(frames_pending_o), 32'd2);
        chk("t2_free", 32'(free_words_o), 32'd509);
        wait_beats("t2_replay", 3);
        chk("t2_r0_data", q[0].data, 32'hC0);
        chk("t2_r0_seq", 32'(q[0].seq), 32'd1);
        chk("t2_r0_act", 32'(q[0].act), 32'd1);
        chk("t2_r2_data", q[2].data, 32'hD1);
        chk("t2_r2_seq", 32'(q[2].seq), 32'd2);
        chk("t2_r2_act", 32'(q[2].act), 32'd1);
        tick(3);
        chk("t2_active_clr", 32'(replay_active_o), 32'd0);
        chk("t2_no_roll", 32'(roll_cnt), 32'd0);

        // 3: replay timer, REPLAY_NUM rollover, reset by ACK
        do_reset();
        send_frame(1, 32'hE0);
        wait_beats("t3_first", 1);
        tick(2);
        for (int r = 0; r < 5; r++) begin
            q.delete();
            replay();
            wait_beats("t3_replay", 1);
            chk("t3_seq", 32'(q[0].seq), 32'd0);
            chk("t3_act", 32'(q[0].act), 32'd1);
            tick(2);
            chk("t3_roll", 32'(roll_cnt), (r >= 3) ? 32'd1 : 32'd0);
        end
        ack(1'b0, 12'd0);
        chk("t3_ack_pending", 32'(frames_pending_o), 32'd0);
        q.delete();
        replay();
        tick(5);
        chk("t3_ignored", 32'(q.size()), 32'd0);
        send_frame(1, 32'hE1);
        wait_beats("t3_f1", 1);
        chk("t3_f1_seq", 32'(q[0].seq), 32'd1);
        tick(2);
        for (int r = 0; r < 3; r++) begin
            replay();
            tick(4);
        end
        chk("t3_num_reset", 32'(roll_cnt), 32'd1);

        // 4: all descriptor slots full, then ACK frees four
        do_reset();
        for (int i = 0; i < 16; i++) send_frame(1, 32'h100 + 32'(i));
        chk("t4_tready_full", 32'(s_axis_tready), 32'd0);
        chk("t4_pending_full", 32'(frames_pending_o), 32'd16);
        wait_beats("t4_beats", 16);
        chk("t4_last_seq", 32'(q[15].seq), 32'd15);
        tick(2);
        ack(1'b0, 12'd3);
        chk("t4_tready_back", 32'(s_axis_tready), 32'd1);
        chk("t4_pending", 32'(frames_pending_o), 32'd12);
        chk("t4_free", 32'(free_words_o), 32'd500);
        ack(1'b0, 12'd20);
        tick(1);
        chk("t4_err", 32'(err_cnt), 32'd1);
        chk("t4_err_nopurge", 32'(frames_pending_o), 32'd12);

        // 6: duplicate NAK replays all, async reset mid-frame during replay
        do_reset();
        send_frame(2, 32'hF0);
        send_frame(2, 32'hF2);
        send_frame(2, 32'hF4);
        wait_beats("t6_first", 6);
        tick(2);
        q.delete();
        ack(1'b1, 12'hFFF);
        wait_beats("t6_replay", 5);
        chk("t6_q0_seq", 32'(q[0].seq), 32'd0);
        chk("t6_q2_seq", 32'(q[2].seq), 32'd1);
        chk("t6_q4_data", q[4].data, 32'hF4);
        chk("t6_q4_act", 32'(q[4].act), 32'd1);
        chk("t6_dup_noerr", 32'(err_cnt), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_rst_tdata", m_axis_tdata, 32'd0);
        chk("t6_rst_active", 32'(replay_active_o), 32'd0);
        chk("t6_rst_pending", 32'(frames_pending_o), 32'd0);
        chk("t6_rst_next_seq", 32'(next_seq_o), 32'd0);
        chk("t6_rst_free", 32'(free_words_o), 32'd512);
        tick(1);
        rst = 1'b0;
        tick(1);
        q.delete();
        err_cnt = 0;
        send_frame(1, 32'hAB);
        wait_beats("t6_new", 1);
        chk("t6_new_seq", 32'(q[0].seq), 32'd0);
        chk("t6_new_data", q[0].data, 32'hAB);

        // 5: advance next_seq to 4094, then wrap through 0
        cnt = 0;
        guard = 0;
        while (next_seq_o != 12'd4094 && guard < 5000) begin
            send_frame(1, 32'(guard));
            guard++;
            cnt++;
            if (cnt == 8 || next_seq_o == 12'd4094) begin
                tick(4);
                ack(1'b0, 12'(next_seq_o - 12'd1));
                cnt = 0;
                q.delete();
            end
        end
        chk("t5_next_seq", 32'(next_seq_o), 32'd4094);
        chk("t5_pending0", 32'(frames_pending_o), 32'd0);
        chk("t5_free0", 32'(free_words_o), 32'd512);
        chk("t5_no_err", 32'(err_cnt), 32'd0);
        send_frame(1, 32'hC0);
        send_frame(1, 32'hC1);
        send_frame(1, 32'hC2);
        wait_beats("t5_beats", 3);
        chk("t5_seq0", 32'(q[0].seq), 32'd4094);
        chk("t5_seq1", 32'(q[1].seq), 32'd4095);
        chk("t5_seq2", 32'(q[2].seq), 32'd0);
        chk("t5_next_wrap", 32'(next_seq_o), 32'd1);
        tick(2);
        ack(1'b0, 12'd0);
        chk("t5_purge_all", 32'(frames_pending_o), 32'd0);
        chk("t5_free", 32'(free_words_o), 32'd512);
        ack(1'b0, 12'd0);
        tick(1);
        chk("t5_dup_ack", 32'(err_cnt), 32'd0);
        ack(1'b0, 12'd4000);
        tick(1);
        chk("t5_ack_err", 32'(err_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_replay_buffer.md
Name: axis_replay_buffer

Overview:
Multi-frame TLP replay buffer for the DLL transmit path. It stores complete AXIS TLP frames and tags each with a sequence number. Each frame is transmitted once, in order, and kept until acknowledged. ACK/NAK DLLP results purge acknowledged frames; a NAK or a replay-timer request retransmits all unacknowledged frames, oldest first. It sits between the TLP source and the DLL framer, and generalises the single-frame retry FIFO to many outstanding frames.

Parameters:
DATA_WIDTH, 32, TLP beat width
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
USER_WIDTH, 1, tuser width
DEPTH_WORDS, 512, data RAM beats; power of 2; must be >= largest frame in beats
MAX_FRAMES, 16, descriptor slots; power of 2
SEQ_WIDTH, 12, sequence number width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
s_axis_tdata/tkeep/tuser  in  DATA_WIDTH/KEEP_WIDTH/USER_WIDTH  TLP input beat
s_axis_tvalid, s_axis_tlast  in  1  input handshake/frame end
s_axis_tready  out  1  input ready
m_axis_tdata/tkeep/tuser  out  DATA/KEEP/USER  TLP output beat
m_axis_tvalid, m_axis_tlast  out  1  output handshake/frame end
m_axis_tready  in  1  downstream ready
m_axis_seq_o  out  SEQ_WIDTH  seq of frame on m_axis; valid with tvalid
ack_valid_i  in  1  ACK/NAK DLLP received (1-cycle pulse)
ack_nak_i  in  1  1=NAK, 0=ACK
ack_seq_i  in  SEQ_WIDTH  AckNak_Seq_Num
replay_req_i  in  1  replay timer expired (pulse)
next_seq_o  out  SEQ_WIDTH  seq assigned to next committed frame
frames_pending_o  out  $clog2(MAX_FRAMES)+1  committed, unpurged frames
free_words_o  out  $clog2(DEPTH_WORDS)+1  free RAM beats
replay_active_o  out  1  high while replaying
replay_rollover_o  out  1  1-cycle pulse on REPLAY_NUM rollover
ack_err_o  out  1  1-cycle pulse on out-of-window ACK/NAK

Behaviour:
- Reset values: all pointers/counts 0; next_seq_o=0; REPLAY_NUM=0; free_words_o=DEPTH_WORDS; all other outputs 0. Reset mid-frame discards the partial frame and all stored frames.
- Write:
  - s_axis_tready = (free words > 0) and not (frame slots full and no frame in progress).
  - Each accepted beat is written at wr_ptr; the pointer wraps modulo DEPTH_WORDS.
  - On an accepted tlast, a descriptor {start, end, seq=next_seq} is pushed, and next_seq increments modulo 2^SEQ_WIDTH.
  - Frames are store-and-forward: a frame is visible to transmit no earlier than the cycle after its tlast is accepted.
- Transmit FSM:
  - IDLE -> XMIT when tx_idx != commit_idx or a replay is pending.
  - XMIT presents the beat at rd_ptr combinationally from registered state and advances on tvalid&tready.
  - On the last beat: tx_idx++; the high-water mark hwm_idx = max(hwm_idx, tx_idx), computed in frame-index modulo arithmetic. Then XMIT (next frame) or IDLE.
  - A frame is never truncated mid-packet.
- Replay:
  - NAK or replay_req_i with frames sent but unacked (hwm_idx != oldest_idx) sets replay_pending.
  - At the next frame boundary (immediately if IDLE): tx_idx = oldest_idx, replay_active_o=1, REPLAY_NUM++.
  - If REPLAY_NUM was 3, it wraps to 0 and replay_rollover_o pulses; the replay still proceeds.
  - replay_active_o clears when tx_idx reaches hwm_idx.
  - A replay request while already replaying re-arms pending; that replay restarts after the current frame.
  - A request with nothing unacked is ignored.
- ACK/NAK purge:
  - n = (ack_seq_i - oldest_seq + 1) mod 2^SEQ_WIDTH.
  - If 1 <= n <= (hwm_idx - oldest_idx): purge n frames (oldest_idx += n, words freed) and reset REPLAY_NUM to 0.
  - If n = 0, i.e. ack_seq_i = oldest_seq - 1 (duplicate): no purge, no error. A NAK in this case still schedules a replay.
  - Otherwise: ack_err_o pulses and nothing is purged or replayed.
  - If tx_idx falls behind the new oldest_idx, it jumps to oldest_idx at the next frame boundary. Purged frames are never re-sent.
- Simultaneous events:
  - The purge is applied before a same-cycle replay_req_i or NAK, so only the remaining frames are replayed.
  - Write and purge in the same cycle both update the free count: free' = free - written + purged.
- Sequence numbers wrap 2^SEQ_WIDTH-1 -> 0; all window compares use modulo subtraction.

Decomposition:
- pcie_datalink_pkg: replay_desc_t {start_ptr, end_ptr, seq}, the seq_diff modulo-subtract function, and the REPLAY_NUM width constant.
- One sub-module, replay_buffer_ram: a simple dual-port beat RAM (tdata/tkeep/tuser/tlast), with a synchronous write and an asynchronous read port.

Test Plan:
1. Send a 3-beat frame, then pulse ACK seq 0 -> m_axis emits 3 beats with m_axis_seq_o=0; after the ACK, free_words_o=512 and frames_pending_o=0.
2. Send frames with seq 0,1,2, then NAK seq 0 -> frame 0 is purged; frames 1 then 2 are replayed with replay_active_o high; REPLAY_NUM=1.
3. Send frame 0 with no ACK, then pulse replay_req_i 4 times -> 4 replays of frame 0; replay_rollover_o pulses on the 4th only; a subsequent ACK 0 resets REPLAY_NUM.
4. Fill all 16 descriptors (or 512 words) -> s_axis_tready=0; then ACK seq 3 -> s_axis_tready returns to 1 the next cycle.
5. Preload next_seq to 4094 (send 4094 frames, ACKing them), send 3 frames (seq 4094, 4095, 0), then ACK seq 0 -> all 3 purged. A later ACK 4000 -> ack_err_o pulse.
6. Assert rst_i asynchronously mid-beat of frame 2 during a replay -> all outputs 0 immediately; after release, a new frame gets seq 0.
